// File: rtl/aes_io_pkg.sv
// Shared constants and FSM state type for the AES text_out read path.
package aes_io_pkg;

    localparam int BLOCK_W         = 128;
    localparam int WORD_W          = 32;
    localparam int WORDS_PER_BLOCK = BLOCK_W / WORD_W;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } reader_state_t;

endpackage

// File: rtl/aes_block_buf.sv
// DEPTH-entry register-array FIFO of cipher blocks; exposes the head and the entry behind it.
module aes_block_buf
    import aes_io_pkg::*;
#(
    parameter int DEPTH   = 2,
    parameter int BLK_W   = BLOCK_W,
    parameter int PTR_W   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [BLK_W-1:0] din,
    output logic             full,
    output logic             empty,
    output logic [PTR_W:0]   count,
    output logic [BLK_W-1:0] head,
    output logic [BLK_W-1:0] head_next
);

    logic [BLK_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr_nx;
    logic [PTR_W:0]   count_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage needs no reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= din;
    end

    assign rd_ptr_nx = rd_ptr + 1'b1;
    assign count     = count_q;
    assign full      = (count_q == (PTR_W + 1)'(DEPTH));
    assign empty     = (count_q == '0);
    assign head      = mem[rd_ptr];
    assign head_next = mem[rd_ptr_nx];

endmodule

// File: rtl/aes_text_out_reader.sv
// Captures AES text_out blocks on done and streams them MSW-first as valid/ready words.
//   state | meaning
//   IDLE  | nothing being offered; leave when the buffer holds a block
//   SEND  | m_valid high, offering word idx_q of the head block
module aes_text_out_reader
    import aes_io_pkg::*;
#(
    parameter int BLOCK_W = aes_io_pkg::BLOCK_W,
    parameter int WORD_W  = aes_io_pkg::WORD_W,
    parameter int DEPTH   = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               done,
    input  logic [BLOCK_W-1:0] text_out,
    output logic               m_valid,
    input  logic               m_ready,
    output logic [WORD_W-1:0]  m_data,
    output logic               m_last,
    output logic               overflow,
    output logic               busy
);

    localparam int WORDS = BLOCK_W / WORD_W;
    localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    reader_state_t      state_q, state_n;
    logic [IDX_W-1:0]   idx_q, idx_n, idx_nx;
    logic               valid_q, valid_n;
    logic [WORD_W-1:0]  data_q, data_n;
    logic               last_q, last_n;
    logic               ovf_q, ovf_n;

    logic               handshake, retire, push, pop;
    logic               buf_full, buf_empty, more_queued;
    logic [CNT_W-1:0]   buf_count;
    logic [BLOCK_W-1:0] buf_head, buf_head_next, next_block;

    function automatic logic [WORD_W-1:0] sel_word(input logic [BLOCK_W-1:0] blk, input int k);
        return blk[BLOCK_W-1-k*WORD_W -: WORD_W];
    endfunction

    aes_block_buf #(
        .DEPTH (DEPTH),
        .BLK_W (BLOCK_W),
        .PTR_W (PTR_W)
    ) u_buf (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .pop       (pop),
        .din       (text_out),
        .full      (buf_full),
        .empty     (buf_empty),
        .count     (buf_count),
        .head      (buf_head),
        .head_next (buf_head_next)
    );

    assign handshake = valid_q && m_ready;
    assign retire    = handshake && last_q;
    assign pop       = retire;
    // A retiring block frees its slot in the same cycle, so a full buffer can still accept.
    assign push      = done && (!buf_full || retire);
    assign idx_nx    = idx_q + 1'b1;
    assign more_queued = (buf_count > CNT_W'(1));
    // After a retire the new head is the entry behind it, or the block being written right now.
    assign next_block  = more_queued ? buf_head_next : text_out;

    always_comb begin
        state_n = state_q;
        idx_n   = idx_q;
        valid_n = valid_q;
        data_n  = data_q;
        last_n  = last_q;
        ovf_n   = ovf_q || (done && buf_full && !retire);
        case (state_q)
            IDLE: begin
                if (!buf_empty) begin
                    state_n = SEND;
                    idx_n   = '0;
                    valid_n = 1'b1;
                    data_n  = sel_word(buf_head, 0);
                    last_n  = (WORDS == 1);
                end
            end
            SEND: begin
                if (handshake) begin
                    if (last_q) begin
                        idx_n = '0;
                        if (more_queued || push) begin
                            data_n = sel_word(next_block, 0);
                            last_n = (WORDS == 1);
                        end else begin
                            state_n = IDLE;
                            valid_n = 1'b0;
                            last_n  = 1'b0;
                        end
                    end else begin
                        idx_n  = idx_nx;
                        data_n = sel_word(buf_head, int'(idx_nx));
                        last_n = (idx_nx == IDX_W'(WORDS - 1));
                    end
                end
            end
            default: begin
                state_n = IDLE;
                valid_n = 1'b0;
                last_n  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            valid_q <= 1'b0;
            data_q  <= '0;
            last_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_n;
            idx_q   <= idx_n;
            valid_q <= valid_n;
            data_q  <= data_n;
            last_q  <= last_n;
            ovf_q   <= ovf_n;
        end
    end

    assign m_valid  = valid_q;
    assign m_data   = data_q;
    assign m_last   = last_q;
    assign overflow = ovf_q;
    assign busy     = (buf_count != '0);

endmodule

// File: tb/tb_aes_text_out_reader.sv
// Directed bench for aes_text_out_reader: vector table plus a hand-written latency sequence.
module tb_aes_text_out_reader;

    logic         clk;
    logic         rst;
    logic         done;
    logic [127:0] text_out;
    logic         m_valid;
    logic         m_ready;
    logic [31:0]  m_data;
    logic         m_last;
    logic         overflow;
    logic         busy;

    int checks = 0;
    int passes = 0;

    typedef struct {
        logic         rst;
        logic         done;
        logic [127:0] text;
        logic         ready;
        logic         exp_valid;
        logic [31:0]  exp_data;
        logic         exp_last;
        logic         exp_ovf;
        logic         exp_busy;
    } vec_t;

    vec_t vecs[$];

    localparam logic [127:0] BLK_T = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] BLK_A = 128'hA0A0A0A0_A1A1A1A1_A2A2A2A2_A3A3A3A3;
    localparam logic [127:0] BLK_B = 128'hB0B0B0B0_B1B1B1B1_B2B2B2B2_B3B3B3B3;
    localparam logic [127:0] BLK_C = 128'hC0C0C0C0_C1C1C1C1_C2C2C2C2_C3C3C3C3;
    localparam logic [127:0] BLK_D = 128'hD0D0D0D0_D1D1D1D1_D2D2D2D2_D3D3D3D3;
    localparam logic [127:0] BLK_X = 128'h11111111_22222222_33333333_44444444;
    localparam logic [127:0] BLK_Y = 128'h55555555_66666666_77777777_88888888;

    aes_text_out_reader dut (
        .clk      (clk),
        .rst      (rst),
        .done     (done),
        .text_out (text_out),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .m_data   (m_data),
        .m_last   (m_last),
        .overflow (overflow),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] wd(input logic [127:0] blk, input int k);
        logic [127:0] b;
        b = blk;
        return b[127 - 32*k -: 32];
    endfunction

    task automatic v(input logic r, input logic d, input logic [127:0] t, input logic rdy,
                     input logic ev, input logic [31:0] ed, input logic el,
                     input logic eo, input logic eb);
        vec_t e;
        e.rst = r; e.done = d; e.text = t; e.ready = rdy;
        e.exp_valid = ev; e.exp_data = ed; e.exp_last = el; e.exp_ovf = eo; e.exp_busy = eb;
        vecs.push_back(e);
    endtask

    // Stream every word of blk with ready high; ovf is the expected sticky flag value.
    task automatic stream(input logic [127:0] blk, input int first, input logic ovf);
        for (int k = first; k < 4; k++)
            v(0, 0, '0, 1, 1, wd(blk, k), (k == 3), ovf, 1);
    endtask

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s vec=%0d actual=%h required=%h", name, idx, act, exp);
    endtask

    initial begin
        int lat;
        rst = 1'b1; done = 1'b0; text_out = '0; m_ready = 1'b0;

        // reset state
        v(1, 0, '0, 0, 0, 32'h0, 0, 0, 0);
        v(0, 0, '0, 0, 0, 32'h0, 0, 0, 0);

        // single block, test-plan words written out by hand
        v(0, 1, BLK_T, 1, 0, 32'h0, 0, 0, 1);
        v(0, 0, '0, 1, 1, 32'h69c4e0d8, 0, 0, 1);
        v(0, 0, '0, 1, 1, 32'h6a7b0430, 0, 0, 1);
        v(0, 0, '0, 1, 1, 32'hd8cdb780, 0, 0, 1);
        v(0, 0, '0, 1, 1, 32'h70b4c55a, 1, 0, 1);
        v(0, 0, '0, 1, 0, 32'h0, 0, 0, 0);

        // backpressure on word 1
        v(0, 1, BLK_T, 1, 0, 32'h0, 0, 0, 1);
        v(0, 0, '0, 1, 1, 32'h69c4e0d8, 0, 0, 1);
        v(0, 0, '0, 1, 1, 32'h6a7b0430, 0, 0, 1);
        for (int i = 0; i < 5; i++) v(0, 0, '0, 0, 1, 32'h6a7b0430, 0, 0, 1);
        v(0, 0, '0, 1, 1, 32'hd8cdb780, 0, 0, 1);
        v(0, 0, '0, 1, 1, 32'h70b4c55a, 1, 0, 1);
        v(0, 0, '0, 1, 0, 32'h0, 0, 0, 0);

        // back-to-back: 8 valid cycles, last on 4 and 8
        v(0, 1, BLK_X, 1, 0, 32'h0, 0, 0, 1);
        v(0, 1, BLK_Y, 1, 1, wd(BLK_X, 0), 0, 0, 1);
        stream(BLK_X, 1, 0);
        stream(BLK_Y, 0, 0);
        v(0, 0, '0, 1, 0, 32'h0, 0, 0, 0);

        // overflow: C dropped, A then B delivered
        v(0, 1, BLK_A, 0, 0, 32'h0, 0, 0, 1);
        v(0, 1, BLK_B, 0, 1, wd(BLK_A, 0), 0, 0, 1);
        v(0, 1, BLK_C, 0, 1, wd(BLK_A, 0), 0, 1, 1);
        v(0, 0, '0, 0, 1, wd(BLK_A, 0), 0, 1, 1);
        stream(BLK_A, 1, 1);
        stream(BLK_B, 0, 1);
        v(0, 0, '0, 1, 0, 32'h0, 0, 1, 0);

        // mid-stream reset after word 2, then fresh block from word 0
        v(0, 1, BLK_D, 1, 0, 32'h0, 0, 1, 1);
        v(0, 0, '0, 1, 1, wd(BLK_D, 0), 0, 1, 1);
        v(0, 0, '0, 1, 1, wd(BLK_D, 1), 0, 1, 1);
        v(0, 0, '0, 1, 1, wd(BLK_D, 2), 0, 1, 1);
        v(1, 0, '0, 1, 0, 32'h0, 0, 0, 0);
        v(0, 1, BLK_T, 1, 0, 32'h0, 0, 0, 1);
        stream(BLK_T, 0, 0);
        v(0, 0, '0, 1, 0, 32'h0, 0, 0, 0);

        // full plus retire: C captured in the cycle A's last word is accepted
        v(0, 1, BLK_A, 0, 0, 32'h0, 0, 0, 1);
        v(0, 1, BLK_B, 0, 1, wd(BLK_A, 0), 0, 0, 1);
        stream(BLK_A, 1, 0);
        v(0, 1, BLK_C, 1, 1, wd(BLK_B, 0), 0, 0, 1);
        stream(BLK_B, 1, 0);
        stream(BLK_C, 0, 0);
        v(0, 0, '0, 1, 0, 32'h0, 0, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            rst      = vecs[i].rst;
            done     = vecs[i].done;
            text_out = vecs[i].text;
            m_ready  = vecs[i].ready;
            @(posedge clk);
            #1;
            chk("m_valid", i, 32'(m_valid), 32'(vecs[i].exp_valid));
            chk("m_last", i, 32'(m_last), 32'(vecs[i].exp_last));
            chk("overflow", i, 32'(overflow), 32'(vecs[i].exp_ovf));
            chk("busy", i, 32'(busy), 32'(vecs[i].exp_busy));
            if (vecs[i].exp_valid || vecs[i].rst)
                chk("m_data", i, m_data, vecs[i].exp_data);
        end

        // capture-to-first-word latency with a bounded wait
        rst = 1'b0; done = 1'b1; text_out = BLK_Y; m_ready = 1'b0;
        @(posedge clk);
        #1;
        done = 1'b0; text_out = '0;
        lat = 1;
        while (!m_valid && lat < 8) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk("latency", vecs.size(), 32'(lat), 32'd2);
        chk("first_word", vecs.size(), m_data, wd(BLK_Y, 0));
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        chk("stall_hold", vecs.size(), m_data, wd(BLK_Y, 0));
        m_ready = 1'b1;
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        chk("drain_busy", vecs.size(), 32'(busy), 32'd0);
        chk("drain_valid", vecs.size(), 32'(m_valid), 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/aes_text_out_reader.md
# aes_text_out_reader

Consumer-side companion to `aes_cipher_top`. It captures the 128-bit `text_out` block when `done` pulses and holds up to two blocks in a small buffer. It then streams each block as four 32-bit words over a valid/ready interface toward the chip output stage. It sits between the cipher core and the output pad/buffer ring, so the core never stalls on a slow reader.

## Interface
- `BLOCK_W`, default 128: cipher block width. Fixed at 128 for AES.
- `WORD_W`, default 32: output word width. `BLOCK_W` must be an exact multiple of `WORD_W`.
- `DEPTH`, default 2: number of buffered blocks. Must be a power of two, at least 2.
- `clk`, in, 1: single clock. All state updates on the rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `done`, in, 1: single-cycle pulse from the cipher core. `text_out` is valid in that cycle.
- `text_out`, in, `BLOCK_W`: ciphertext block from the core.
- `m_valid`, out, 1: output word available.
- `m_ready`, in, 1: downstream accepts the word.
- `m_data`, out, `WORD_W`: current output word.
- `m_last`, out, 1: marks the final word of a block.
- `overflow`, out, 1: sticky flag. Set when a block is dropped; cleared only by `rst`.
- `busy`, out, 1: high when the buffer is non-empty or a block is mid-stream.

## Operation
- **Reset values:** `m_valid`=0, `m_data`=0, `m_last`=0, `overflow`=0, `busy`=0. Read pointer, write pointer, occupancy count and word index are all 0. The FSM resets to IDLE.
- **Capture:** `done`=1 while occupancy < `DEPTH` writes `text_out` into the slot at the write pointer. The write pointer advances modulo `DEPTH` and occupancy increments.
- **Full drop:** `done`=1 while occupancy == `DEPTH` and no block retires in the same cycle discards the block and sets `overflow`. Pointers are unchanged.
- **Simultaneous capture and retire:** a full buffer with `done` in the same cycle that the final word of a block is accepted captures the new block without loss. Occupancy stays at `DEPTH`.
- **Word order:** most-significant word first. Word k is `text_out[BLOCK_W-1-k*WORD_W -: WORD_W]` for k = 0..3.
- **FSM:**
  - IDLE: `m_valid`=0. If occupancy > 0, go to SEND with word index 0.
  - SEND: `m_valid`=1. `m_data` is the selected word of the head block. `m_last`=1 when word index == 3.
  - On handshake (`m_valid && m_ready`), the word index increments.
  - On a handshake with `m_last`=1: the word index wraps to 0, the read pointer advances, and occupancy decrements. Stay in SEND if a further block is present after the decrement; otherwise go to IDLE.
- **Output stability:** while `m_valid`=1 and `m_ready`=0, `m_data` and `m_last` hold stable. `m_valid` never drops without a handshake.
- **Mid-stream reset:** `rst` asserted during SEND discards all buffered blocks and the partial transfer. Outputs return to reset values in the next cycle.
- **`busy`:** equals (occupancy != 0).

## Timing
- **Capture to first word:** `done` in cycle N gives `m_valid`=1 in cycle N+2 (N+1 entry into IDLE-to-SEND decision, N+2 registered output).
- **Throughput:** with `m_ready` held high, one word per cycle and back-to-back blocks with no bubble. A block takes 4 cycles, so the sustained rate is 1 block per 4 cycles. The core's minimum `done` spacing (about 12 cycles) never overflows at full ready.
- **Registered outputs:** `m_data`, `m_valid` and `m_last` come directly from registers. No combinational path exists from `m_ready` to any output.
- **Visibility:** `overflow` rises in the cycle after the dropping `done`.

## Structure
- **Shared package `aes_io_pkg`:** holds the `BLOCK_W` and `WORD_W` constants, `WORDS_PER_BLOCK` = `BLOCK_W/WORD_W`, and the FSM state enum (IDLE, SEND).
- **Sub-module `aes_block_buf`:** `DEPTH`-entry, `BLOCK_W`-wide register-array FIFO with push, pop, full and empty signals, plus a head-data output. The top level owns the FSM, the word mux, the output registers and `overflow`.
- **Size:** about 200 lines total.

## Test plan
- **Single block:** reset, then `done` with `text_out`=`69c4e0d86a7b0430d8cdb78070b4c55a`, `m_ready`=1. Required response: words `69c4e0d8`, `6a7b0430`, `d8cdb780`, `70b4c55a` on consecutive cycles. `m_last` is high only on the 4th word, and `m_valid` first rises 2 cycles after `done`.
- **Backpressure:** same block with `m_ready` low for 5 cycles on word 1. Required response: `m_data` holds `6a7b0430` and `m_valid` stays high throughout; the stream completes in order.
- **Overflow:** `m_ready`=0, then three `done` pulses with blocks A, B, C. Required response: `overflow`=1 after C. Releasing ready yields A then B only.
- **Full plus retire:** buffer full with A and B, A streaming. `done`(C) in the same cycle A's `m_last` handshake occurs. Required response: `overflow` stays 0 and the output order is B then C.
- **Mid-stream reset:** `rst` asserted after word 2 of a block. Required response: the next cycle shows `m_valid`=0, `busy`=0, `overflow`=0. A new block afterward streams from word 0.
- **Back-to-back:** two blocks captured, `m_ready`=1. Required response: 8 consecutive valid cycles with no gap, `m_last` on cycles 4 and 8.
